// File: rtl/motor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | motor_pkg: shared types, direction constants and helpers  | rev 1.0      |
// +--------------------------------------------------------------------------+
package motor_pkg;

  typedef enum logic [1:0] {
    S_STOP    = 2'd0,
    S_RAMP    = 2'd1,
    S_HOLD    = 2'd2,
    S_REVERSE = 2'd3
  } state_e;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  function automatic int level_width(input int levels);
    return (levels > 1) ? $clog2(levels) : 1;
  endfunction

  function automatic logic [3:0] bcd_tens(input logic [7:0] v);
    return 4'(v / 8'd10);
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [7:0] v);
    return 4'(v % 8'd10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_debounce: 2-flop sync, tick-sampled debounce, press pulse | rev 1.0 |
// +--------------------------------------------------------------------------+
module button_debounce #(
  parameter int DEB_TICKS = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEB_TICKS + 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Any tick sample that agrees with the accepted level restarts the run.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (tick_i) begin
      if (sync_q[1] == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DEB_TICKS - 1)) begin
        level_d = sync_q[1];
        cnt_d   = '0;
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/motor_speed_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | motor_speed_ctrl: buttons -> target, ramped level, PWM, H-bridge | rev 1.0 |
// +--------------------------------------------------------------------------+
module motor_speed_ctrl
  import motor_pkg::*;
#(
  parameter int  LEVELS     = 11,
  parameter int  PWM_PERIOD = 500,
  parameter int  TICK_DIV   = 50000,
  parameter int  DEB_TICKS  = 10,
  parameter int  RAMP_TICKS = 100,
  localparam int LW         = level_width(LEVELS)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_up,
  input  logic          i_down,
  input  logic          i_rev,
  output logic          o_pwm,
  output logic          o_in1,
  output logic          o_in2,
  output logic [LW-1:0] o_level,
  output logic [3:0]    o_tens,
  output logic [3:0]    o_ones,
  output logic          o_busy
);

  localparam int STEP = PWM_PERIOD / (LEVELS - 1);
  localparam int TW   = $clog2(TICK_DIV + 1);
  localparam int RW   = $clog2(RAMP_TICKS + 1);
  localparam int PW   = $clog2(PWM_PERIOD + 1);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Assertion is immediate; release is delayed two clocks to avoid recovery hazards.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [TW-1:0] tick_cnt_q;
  logic [RW-1:0] ramp_cnt_q;
  logic [PW-1:0] pwm_cnt_q, duty_q;
  logic [LW-1:0] target_q, target_d;
  logic [LW-1:0] applied_q, applied_d;
  logic          req_dir_q, dir_q, dir_d;
  logic [3:0]    tens_q, ones_q;
  state_e        state_q, state_d;

  logic tick, ramp_wrap, strobe, pwm_wrap;
  logic up_p, down_p, rev_p;

  assign tick      = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign ramp_wrap = (ramp_cnt_q == RW'(RAMP_TICKS - 1));
  assign strobe    = tick & ramp_wrap;
  assign pwm_wrap  = (pwm_cnt_q == PW'(PWM_PERIOD - 1));

  button_debounce #(.DEB_TICKS(DEB_TICKS)) u_up (
    .clk_i(i_clk), .rst_ni(rst_n), .tick_i(tick), .btn_i(i_up), .press_o(up_p)
  );
  button_debounce #(.DEB_TICKS(DEB_TICKS)) u_down (
    .clk_i(i_clk), .rst_ni(rst_n), .tick_i(tick), .btn_i(i_down), .press_o(down_p)
  );
  button_debounce #(.DEB_TICKS(DEB_TICKS)) u_rev (
    .clk_i(i_clk), .rst_ni(rst_n), .tick_i(tick), .btn_i(i_rev), .press_o(rev_p)
  );

  always_comb begin
    target_d = target_q;
    if (up_p && !down_p && target_q != LW'(LEVELS - 1)) begin
      target_d = target_q + LW'(1);
    end else if (down_p && !up_p && target_q != '0) begin
      target_d = target_q - LW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    applied_d = applied_q;
    dir_d     = dir_q;
    if (strobe) begin
      unique case (state_q)
        S_STOP: begin
          applied_d = '0;
          if (target_q != '0) begin
            dir_d   = req_dir_q;
            state_d = S_RAMP;
          end
        end
        S_RAMP: begin
          if (req_dir_q != dir_q) begin
            state_d = S_REVERSE;
          end else begin
            if (applied_q < target_q)      applied_d = applied_q + LW'(1);
            else if (applied_q > target_q) applied_d = applied_q - LW'(1);
            if (applied_d == target_q) state_d = (target_q == '0) ? S_STOP : S_HOLD;
          end
        end
        S_HOLD: begin
          if (req_dir_q != dir_q)        state_d = S_REVERSE;
          else if (target_q != applied_q) state_d = S_RAMP;
        end
        S_REVERSE: begin
          // A second reverse press before zero cancels the reversal.
          if (req_dir_q == dir_q) begin
            state_d = S_RAMP;
          end else if (applied_q <= LW'(1)) begin
            applied_d = '0;
            dir_d     = req_dir_q;
            state_d   = S_STOP;
          end else begin
            applied_d = applied_q - LW'(1);
          end
        end
        default: state_d = S_STOP;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_STOP;
      applied_q <= '0;
      dir_q     <= DIR_FWD;
    end else begin
      state_q   <= state_d;
      applied_q <= applied_d;
      dir_q     <= dir_d;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      ramp_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      duty_q     <= '0;
      target_q   <= '0;
      req_dir_q  <= DIR_FWD;
      tens_q     <= '0;
      ones_q     <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
      if (tick) ramp_cnt_q <= ramp_wrap ? '0 : ramp_cnt_q + RW'(1);
      pwm_cnt_q  <= pwm_wrap ? '0 : pwm_cnt_q + PW'(1);
      // New duty takes effect on the same edge the counter returns to 0.
      if (pwm_wrap) duty_q <= PW'(applied_q) * PW'(STEP);
      target_q   <= target_d;
      req_dir_q  <= req_dir_q ^ rev_p;
      tens_q     <= bcd_tens(8'(target_q));
      ones_q     <= bcd_ones(8'(target_q));
    end
  end

  assign o_pwm   = (pwm_cnt_q < duty_q);
  assign o_in1   = (applied_q != '0) && (dir_q == DIR_FWD);
  assign o_in2   = (applied_q != '0) && (dir_q == DIR_REV);
  assign o_level = applied_q;
  assign o_tens  = tens_q;
  assign o_ones  = ones_q;
  assign o_busy  = (state_q == S_RAMP) || (state_q == S_REVERSE);

endmodule
`default_nettype wire

// File: tb/tb_motor_speed_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_motor_speed_ctrl: scoreboard bench for motor_speed_ctrl  | rev 1.0    |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_motor_speed_ctrl;
  import motor_pkg::*;

  localparam int B_UP = 0, B_DOWN = 1, B_REV = 2;

  logic       clk = 1'b0, rst_n = 1'b1, up = 1'b0, down = 1'b0, rev = 1'b0;
  logic       pwm, in1, in2, busy;
  logic [3:0] level, tens, ones;

  int n_checks = 0, n_fail = 0, cyc = 0;
  // Entry = {level, in1, in2} expected at each successive change of o_level.
  logic [5:0] exp_q[$];
  bit         mon_en = 1'b0;
  logic [3:0] prev_level = 4'd0;

  motor_speed_ctrl #(
    .LEVELS(11), .PWM_PERIOD(20), .TICK_DIV(4), .DEB_TICKS(2), .RAMP_TICKS(2)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_up(up), .i_down(down), .i_rev(rev),
    .o_pwm(pwm), .o_in1(in1), .o_in2(in2), .o_level(level),
    .o_tens(tens), .o_ones(ones), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [5:0] e;
    n_checks++;
    if (in1 && in2) begin
      n_fail++;
      $display("FAIL legs_exclusive: in1=%b in2=%b, required never both 1", in1, in2);
    end
    if (mon_en && level !== prev_level) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL level_step: got level=%0d legs=%b%b, required no change", level, in1, in2);
      end else begin
        e = exp_q.pop_front();
        if ({level, in1, in2} !== e) begin
          n_fail++;
          $display("FAIL level_step: got level=%0d legs=%b%b, required level=%0d legs=%b%b",
                   level, in1, in2, e[5:2], e[1], e[0]);
        end
      end
    end
    prev_level = level;
  end

  task automatic set_btn(input int which, input logic v);
    case (which)
      B_UP:    up = v;
      B_DOWN:  down = v;
      default: rev = v;
    endcase
  endtask

  task automatic press(input int which, input int hi, input int lo);
    set_btn(which, 1'b1);
    repeat (hi) @(negedge clk);
    set_btn(which, 1'b0);
    repeat (lo) @(negedge clk);
  endtask

  task automatic push_lv(input int l, input logic a, input logic b);
    exp_q.push_back({4'(l), a, b});
  endtask

  task automatic wait_drain(input int max, output bit to);
    to = 1'b1;
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0) begin to = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_level(input logic [3:0] v, input int max, output bit to, output int t);
    to = 1'b1;
    t  = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (level == v) begin to = 1'b0; t = cyc; break; end
    end
  endtask

  task automatic count_pwm(output int n);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (pwm) n++;
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({pwm, in1, in2, busy, level, tens, ones} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0000", {pwm, in1, in2, busy, level, tens, ones});
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if ({pwm, in1, in2, busy, level, tens, ones} !== 16'h0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %h, required 0000", {pwm, in1, in2, busy, level, tens, ones});
    end
    n_checks++;
    if (dut.state_q !== S_STOP) begin
      n_fail++;
      $display("FAIL idle_state: got %0d, required %0d", dut.state_q, S_STOP);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_bounce();
    bit to;
    // Toggling every 4 cycles makes consecutive tick samples always disagree.
    for (int i = 0; i < 10; i++) begin
      up = ~up;
      repeat (4) @(negedge clk);
    end
    up = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if ({tens, ones} !== 8'h00) begin
      n_fail++;
      $display("FAIL bounce_target: got %0d%0d, required 00", tens, ones);
    end
    push_lv(1, 1'b1, 1'b0);
    press(B_UP, 30, 30);
    wait_drain(100, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL clean_press_ramp: got timeout, required level 1"); end
    n_checks++;
    if ({tens, ones} !== 8'h01) begin
      n_fail++;
      $display("FAIL clean_press_bcd: got %0d%0d, required 01", tens, ones);
    end
  endtask

  task automatic test_ramp();
    bit to;
    int n;
    do_reset();
    for (int l = 1; l <= 5; l++) push_lv(l, 1'b1, 1'b0);
    repeat (5) press(B_UP, 30, 30);
    wait_drain(200, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL ramp_drain: got timeout, required levels 1..5"); end
    repeat (40) @(negedge clk);
    n_checks++;
    if ({busy, in1, in2, level} !== {3'b010, 4'd5}) begin
      n_fail++;
      $display("FAIL ramp_hold: got busy=%b legs=%b%b level=%0d, required busy=0 legs=10 level=5",
               busy, in1, in2, level);
    end
    count_pwm(n);
    n_checks++;
    if (n != 10) begin n_fail++; $display("FAIL ramp_pwm: got %0d high of 20, required 10", n); end
    n_checks++;
    if ({tens, ones} !== 8'h05) begin
      n_fail++;
      $display("FAIL ramp_bcd: got %0d%0d, required 05", tens, ones);
    end
  endtask

  task automatic test_saturation();
    bit to;
    int n;
    for (int l = 6; l <= 10; l++) push_lv(l, 1'b1, 1'b0);
    repeat (12) press(B_UP, 30, 30);
    wait_drain(200, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL sat_up_drain: got timeout, required levels 6..10"); end
    n_checks++;
    if ({tens, ones} !== 8'h10) begin
      n_fail++;
      $display("FAIL sat_up_bcd: got %0d%0d, required 10", tens, ones);
    end
    repeat (40) @(negedge clk);
    count_pwm(n);
    n_checks++;
    if (n != 20) begin n_fail++; $display("FAIL sat_up_pwm: got %0d high of 20, required 20", n); end
    for (int l = 9; l >= 1; l--) push_lv(l, 1'b1, 1'b0);
    push_lv(0, 1'b0, 1'b0);
    repeat (12) press(B_DOWN, 30, 30);
    wait_drain(200, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL sat_down_drain: got timeout, required levels 9..0"); end
    repeat (40) @(negedge clk);
    count_pwm(n);
    n_checks++;
    if (n != 0) begin n_fail++; $display("FAIL sat_down_pwm: got %0d high of 20, required 0", n); end
    n_checks++;
    if ({tens, ones, busy, in1, in2} !== 11'h0) begin
      n_fail++;
      $display("FAIL sat_down_state: got bcd=%0d%0d busy=%b legs=%b%b, required 00 0 00",
               tens, ones, busy, in1, in2);
    end
  endtask

  task automatic test_reverse();
    bit to, to2, to1, to0;
    int t2, t1, t0;
    for (int l = 1; l <= 3; l++) push_lv(l, 1'b1, 1'b0);
    repeat (3) press(B_UP, 30, 30);
    wait_drain(200, to);
    repeat (20) @(negedge clk);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL rev_setup: got timeout, required level 3"); end
    push_lv(2, 1'b1, 1'b0); push_lv(1, 1'b1, 1'b0); push_lv(0, 1'b0, 1'b0);
    push_lv(1, 1'b0, 1'b1); push_lv(2, 1'b0, 1'b1); push_lv(3, 1'b0, 1'b1);
    fork
      press(B_REV, 30, 30);
      begin
        wait_level(4'd2, 200, to2, t2);
        n_checks++;
        if (to2 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL rev_busy: got timeout=%b busy=%b, required 0 1", to2, busy);
        end
        wait_level(4'd1, 50, to1, t1);
        wait_level(4'd0, 50, to0, t0);
        n_checks++;
        if (to1 || to0 || (t1 - t2) != 8 || (t0 - t1) != 8) begin
          n_fail++;
          $display("FAIL rev_step_gap: got gaps %0d,%0d (timeout %b%b), required 8,8",
                   t1 - t2, t0 - t1, to1, to0);
        end
      end
    join
    wait_drain(200, to);
    repeat (20) @(negedge clk);
    n_checks++;
    if (to || {busy, in1, in2, level} !== {3'b001, 4'd3}) begin
      n_fail++;
      $display("FAIL rev_final: got timeout=%b busy=%b legs=%b%b level=%0d, required 0 0 01 3",
               to, busy, in1, in2, level);
    end
  endtask

  task automatic test_abort_and_simultaneous();
    bit to;
    logic [3:0] min_lv;
    bit saw_in2;
    do_reset();
    for (int l = 1; l <= 4; l++) push_lv(l, 1'b1, 1'b0);
    repeat (4) press(B_UP, 30, 30);
    wait_drain(200, to);
    repeat (20) @(negedge clk);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL abort_setup: got timeout, required level 4"); end
    mon_en  = 1'b0;
    min_lv  = 4'd15;
    saw_in2 = 1'b0;
    fork
      begin
        press(B_REV, 12, 12);
        press(B_REV, 12, 12);
      end
      repeat (200) begin
        @(negedge clk);
        if (level < min_lv) min_lv = level;
        if (in2) saw_in2 = 1'b1;
      end
    join
    n_checks++;
    if (min_lv == 4'd0 || min_lv >= 4'd4 || saw_in2) begin
      n_fail++;
      $display("FAIL abort_path: got min level %0d reverse_seen=%b, required 1..3 and 0", min_lv, saw_in2);
    end
    n_checks++;
    if ({busy, in1, in2, level} !== {3'b010, 4'd4}) begin
      n_fail++;
      $display("FAIL abort_final: got busy=%b legs=%b%b level=%0d, required 0 10 4", busy, in1, in2, level);
    end
    mon_en = 1'b1;
    up = 1'b1; down = 1'b1;
    repeat (30) @(negedge clk);
    up = 1'b0; down = 1'b0;
    repeat (50) @(negedge clk);
    n_checks++;
    if ({tens, ones, level} !== {8'h04, 4'd4}) begin
      n_fail++;
      $display("FAIL simultaneous: got bcd=%0d%0d level=%0d, required 04 4", tens, ones, level);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int t, nz;
    mon_en = 1'b0;
    fork
      press(B_REV, 30, 30);
      begin
        wait_level(4'd2, 200, to, t);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (to || {pwm, in1, in2, busy, level, tens, ones} !== 16'h0) begin
          n_fail++;
          $display("FAIL mid_reset: got timeout=%b outputs=%h, required 0 0000",
                   to, {pwm, in1, in2, busy, level, tens, ones});
        end
      end
    join
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    nz = 0;
    repeat (40) begin
      @(negedge clk);
      if ({pwm, in1, in2, busy, level, tens, ones} !== 16'h0) nz++;
    end
    n_checks++;
    if (nz != 0 || dut.state_q !== S_STOP) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %0d nonzero cycles state=%0d, required 0 and %0d",
               nz, dut.state_q, S_STOP);
    end
    up = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ones !== 4'd0) begin
      n_fail++;
      $display("FAIL held_early: got ones=%0d, required 0", ones);
    end
    repeat (40) @(negedge clk);
    n_checks++;
    if (ones !== 4'd1) begin
      n_fail++;
      $display("FAIL held_accept: got ones=%0d, required 1", ones);
    end
    up = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_ramp();
    test_saturation();
    test_reverse();
    test_abort_and_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
